pipeline_hazard_ctrl: RTL

//  Central stall/flush/forwarding controller for the 5-stage rv32i pipeline (IF,ID,EX,MEM,WB).

---
 rtl/pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage rv32i pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned PERF_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wr,
    input  logic             ex_load,
    input  logic             ex_br_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wr,
    input  logic             inst_read,
    input  logic             inst_resp,
    input  logic             data_req,
    input  logic             data_resp,
    output logic             ld_pc,
    output logic             ld_ifid,
    output logic             ld_idex,
    output logic             ld_exmem,
    output logic             ld_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp1,
    output logic             id_byp2,
`ifdef HAZARD_PERF_EN
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_bubble,
    output logic [PERF_W-1:0] perf_flush,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StIWait  = 2'd1,
        StDWait  = 2'd2,
        StIdWait = 2'd3
    } state_e;

    state_e state_q;
    logic   drop_pend_q;

    logic imiss;
    logic dmiss;
    logic mem_stall;
    logic load_use;
    logic squash;
    logic bubble;

    assign imiss     = inst_read & ~inst_resp;
    assign dmiss     = data_req & ~data_resp;
    assign mem_stall = imiss | dmiss;

    assign load_use = ex_load & ex_wr & (ex_rd != '0) &
                      ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));

    // A pending drop finishes a squash that was deferred behind an instruction miss.
    assign squash = ~mem_stall & (ex_br_taken | drop_pend_q);
    assign bubble = ~mem_stall & ~squash & load_use;

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            drop_pend_q <= 1'b0;
        end else begin
            unique case ({dmiss, imiss})
                2'b00:   state_q <= StRun;
                2'b01:   state_q <= StIWait;
                2'b10:   state_q <= StDWait;
                default: state_q <= StIdWait;
            endcase
            if (!mem_stall) begin
                drop_pend_q <= 1'b0;
            end else if (ex_br_taken && imiss) begin
                drop_pend_q <= 1'b1;
            end
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
        logic [1:0] sel;
        sel = 2'd0;
        if (mem_wr && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = 2'd1;
        end else if (wb_wr && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        ld_pc      = 1'b1;
        ld_ifid    = 1'b1;
        ld_idex    = 1'b1;
        ld_exmem   = 1'b1;
        ld_memwb   = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        fwd_a      = 2'd0;
        fwd_b      = 2'd0;
        id_byp1    = 1'b0;
        id_byp2    = 1'b0;
        if (rst) begin
            ld_pc      = 1'b0;
            ld_ifid    = 1'b0;
            ld_idex    = 1'b0;
            ld_exmem   = 1'b0;
            ld_memwb   = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else begin
            fwd_a   = fwd_sel(ex_rs1);
            fwd_b   = fwd_sel(ex_rs2);
            id_byp1 = wb_wr & (wb_rd != '0) & (wb_rd == id_rs1);
            id_byp2 = wb_wr & (wb_rd != '0) & (wb_rd == id_rs2);
            if (mem_stall) begin
                ld_pc    = 1'b0;
                ld_ifid  = 1'b0;
                ld_idex  = 1'b0;
                ld_exmem = 1'b0;
                ld_memwb = 1'b0;
            end else if (squash) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, push a single bubble into EX.
                ld_pc      = 1'b0;
                ld_ifid    = 1'b0;
                flush_idex = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall  <= '0;
            perf_bubble <= '0;
            perf_flush  <= '0;
        end else begin
            if (mem_stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + PERF_W'(1);
            end
            if (bubble && (perf_bubble != '1)) begin
                perf_bubble <= perf_bubble + PERF_W'(1);
            end
            if (squash && (perf_flush != '1)) begin
                perf_flush <= perf_flush + PERF_W'(1);
            end
        end
    end
`else
    // PERF_W only sizes the optional counters; a zero width leaves this marker block behind.
    if (PERF_W == 0) begin : g_perf_w_zero
    end
`endif

endmodule
